display_scanner: RTL and testbench
==================================

DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 The block SHALL have parameter DIV, default 50000, meaning clock cycles each digit stays active; legal range 1 to 2^20-1.
REQ-002 The block SHALL have parameter BLANK_LZ, default 1, meaning leading-zero blanking is enabled when 1.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 valor  input  16  hex value to display; nibble [3:0] is digit 0, the rightmost digit.
REQ-006 load  input  1  one-cycle strobe; valor is sampled on any rising edge where load=1.
REQ-007 dado  output  4  nibble for the current digit, feeding the 7-segment converter.
REQ-008 digit_en_n  output  4  active-low one-hot digit enable; all ones means all digits off.
REQ-009 blank  output  1  high while the current digit is suppressed as a leading zero.
REQ-010 frame_done  output  1  one-cycle pulse marking the start of a new scan frame.

Function
REQ-011 Prescaler counter SHALL count 0..DIV-1 and wrap to 0; tick = (count==DIV-1).
REQ-012 Digit index SHALL follow the scan states SCAN0->SCAN1->SCAN2->SCAN3->SCAN0, advancing only on tick; with DIV=1 it advances every cycle.
REQ-013 Frame boundary SHALL be tick while in SCAN3.
REQ-014 load SHALL write valor into a pending register and set a pending flag; multiple loads within one frame: last one wins.
REQ-015 At a frame boundary the display register SHALL take valor if load=1 on that same edge, else the pending register if the pending flag is set, else it holds; the pending flag clears on that edge.
REQ-016 The display register SHALL never change except at a frame boundary (no mid-frame tearing).
REQ-017 dado SHALL equal display[4i+3:4i] for current index i, driven only from registers with no combinational path from valor or load.
REQ-018 digit_en_n SHALL be ~(1<<i), changing on the same edge the index changes.
REQ-019 With BLANK_LZ=1, digit i SHALL be blanked iff i>0 and display nibbles i..3 are all zero; digit 0 is never blanked.
REQ-020 While blanked: digit_en_n = 4'b1111, blank = 1, and dado = 0.
REQ-021 With BLANK_LZ=0, blank SHALL stay 0.
REQ-022 frame_done SHALL be 1 for exactly the one cycle following the frame-boundary edge, i.e. the first cycle of SCAN0.
REQ-023 Latency from a boundary edge to the new value on dado and digit_en_n SHALL be zero cycles: both are valid in the first cycle of SCAN0.

Reset
REQ-024 While rst_n=0, regardless of clk: count=0, index=SCAN0, display=0, pending=0, pending flag=0.
REQ-025 While rst_n=0, outputs SHALL be dado=0, digit_en_n=4'b1110, blank=0, frame_done=0.
REQ-026 load SHALL be ignored while rst_n=0.
REQ-027 After rst_n rises, the first tick SHALL occur DIV rising edges later.
REQ-028 Reset asserted mid-frame SHALL discard any pending value.

Verification (DIV=4 unless stated)
REQ-029 Reset release, no load, BLANK_LZ=1 -> digit_en_n 1110,1111,1111,1111, each held 4 cycles; dado=0 throughout; blank=0,1,1,1; frame_done pulses every 16 cycles.
REQ-030 load valor=16'h1234 in SCAN1 -> display unchanged until the boundary; then dado 4,3,2,1 with digit_en_n 1110,1101,1011,0111, 4 cycles each.
REQ-031 load 16'h1111 then 16'h2222 within one frame -> next frame shows 2,2,2,2; 16'h1111 never appears on dado.
REQ-032 load 16'h00A0 on the boundary edge -> immediately following frame: SCAN0 dado=0 enabled, SCAN1 dado=A with digit_en_n=1101, SCAN2 and SCAN3 blanked.
REQ-033 DIV=1, display 16'hBEEF -> digit_en_n rotates every cycle; dado F,E,E,B; frame_done high every 4th cycle.
REQ-034 rst_n pulsed low mid-SCAN2 between clock edges -> outputs go to reset values at once (asynchronously); after release, SCAN0 shows 0 and the pending value is lost.

Source files
------------

// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed scan of a 4-digit hex display.
// A prescaler sets how long each digit stays lit. New values are queued
// in a pending register and only copied into the displayed value at a
// frame boundary, so a frame never shows a mix of old and new digits.
//
// state | meaning
// SCAN0 | digit 0 (rightmost) enabled
// SCAN1 | digit 1 enabled
// SCAN2 | digit 2 enabled
// SCAN3 | digit 3 enabled; its last tick is the frame boundary
module display_scanner #(
  parameter int unsigned DIV      = 50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] valor,
  input  logic        load,
  output logic [3:0]  dado,
  output logic [3:0]  digit_en_n,
  output logic        blank,
  output logic        frame_done
);

  typedef enum logic [1:0] {SCAN0, SCAN1, SCAN2, SCAN3} scan_e;

  localparam int unsigned     CW = 20;
  localparam logic [CW-1:0]   TC = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  scan_e         state_q, state_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   pend_q, pend_d;
  logic          pflag_q, pflag_d;
  logic          fdone_q, fdone_d;

  logic          tick;
  logic          boundary;

  assign tick     = (cnt_q == TC);
  assign boundary = tick && (state_q == SCAN3);

  // Registers: prescaler, scan state, display/pending values, frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      state_q <= SCAN0;
      disp_q  <= '0;
      pend_q  <= '0;
      pflag_q <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
      fdone_q <= fdone_d;
    end
  end

  // Next-state: prescaler wrap, digit rotation on tick, load queueing and
  // the frame-boundary commit (a load on the boundary edge itself wins).
  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    state_d = state_q;
    disp_d  = disp_q;
    pend_d  = pend_q;
    pflag_d = pflag_q;
    fdone_d = 1'b0;

    if (tick) begin
      case (state_q)
        SCAN0:   state_d = SCAN1;
        SCAN1:   state_d = SCAN2;
        SCAN2:   state_d = SCAN3;
        SCAN3:   state_d = SCAN0;
        default: state_d = SCAN0;
      endcase
    end

    if (boundary) begin
      if (load) begin
        disp_d = valor;
      end else if (pflag_q) begin
        disp_d = pend_q;
      end
      pflag_d = 1'b0;
      fdone_d = 1'b1;
    end else if (load) begin
      pend_d  = valor;
      pflag_d = 1'b1;
    end
  end

  logic [1:0]  idx;
  logic [15:0] disp_sh;
  logic        blank_c;

  assign idx     = state_q;
  assign disp_sh = disp_q >> {idx, 2'b00};

  // Output decode purely from registers: current nibble, enable, blanking.
  always_comb begin
    blank_c = 1'b0;
    case (state_q)
      SCAN0:   blank_c = 1'b0;
      SCAN1:   blank_c = (disp_q[15:4] == 12'h000);
      SCAN2:   blank_c = (disp_q[15:8] == 8'h00);
      SCAN3:   blank_c = (disp_q[15:12] == 4'h0);
      default: blank_c = 1'b0;
    endcase
    blank_c = blank_c && BLANK_LZ;

    blank      = blank_c;
    dado       = blank_c ? 4'h0 : disp_sh[3:0];
    digit_en_n = blank_c ? 4'b1111 : ~(4'b0001 << idx);
    frame_done = fdone_q;
  end

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: two instances (DIV=4 with blanking, DIV=1
// without) share stimulus; a cycle-count based model predicts outputs.
module tb_display_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] valor = '0;
  logic        load = 1'b0;

  logic [3:0]  dado4, en4, dado1, en1;
  logic        blank4, fd4, blank1, fd1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  display_scanner #(.DIV(4), .BLANK_LZ(1'b1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .valor(valor), .load(load),
    .dado(dado4), .digit_en_n(en4), .blank(blank4), .frame_done(fd4));

  display_scanner #(.DIV(1), .BLANK_LZ(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .valor(valor), .load(load),
    .dado(dado1), .digit_en_n(en1), .blank(blank1), .frame_done(fd1));

  // Model: time since reset release decides digit and frame boundary.
  int          D[2]   = '{4, 1};
  bit          BLZ[2] = '{1'b1, 1'b0};
  int          cyc[2];
  logic [15:0] m_disp[2];
  logic [15:0] m_pend[2];
  bit          m_flag[2];
  bit          m_fd[2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        cyc[k] = 0; m_disp[k] = '0; m_pend[k] = '0; m_flag[k] = 0; m_fd[k] = 0;
      end else begin
        if (cyc[k] % (4 * D[k]) == 4 * D[k] - 1) begin
          if (load) m_disp[k] = valor;
          else if (m_flag[k]) m_disp[k] = m_pend[k];
          m_flag[k] = 0;
          m_fd[k] = 1;
        end else begin
          m_fd[k] = 0;
          if (load) begin
            m_pend[k] = valor;
            m_flag[k] = 1;
          end
        end
        cyc[k]++;
      end
    end
  end

  task automatic cmp(input string nm, input int k, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s[u%0d] t=%0t got %h expected %h", nm, k, $time, got, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int i;
      logic [15:0] upper;
      bit bl;
      logic [3:0] e_dado, e_en;
      i = (cyc[k] / D[k]) % 4;
      upper = m_disp[k] >> (4 * i);
      bl = BLZ[k] && (i > 0) && (upper == 16'h0);
      e_dado = bl ? 4'h0 : upper[3:0];
      e_en = bl ? 4'b1111 : ~(4'b0001 << i);
      if (k == 0) begin
        cmp("dado", k, {12'h0, dado4}, {12'h0, e_dado});
        cmp("digit_en_n", k, {12'h0, en4}, {12'h0, e_en});
        cmp("blank", k, {15'h0, blank4}, {15'h0, bl});
        cmp("frame_done", k, {15'h0, fd4}, {15'h0, m_fd[k]});
      end else begin
        cmp("dado", k, {12'h0, dado1}, {12'h0, e_dado});
        cmp("digit_en_n", k, {12'h0, en1}, {12'h0, e_en});
        cmp("blank", k, {15'h0, blank1}, {15'h0, bl});
        cmp("frame_done", k, {15'h0, fd1}, {15'h0, m_fd[k]});
      end
    end
  endtask

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) check_all();

  task automatic lit4(input string nm, input logic [3:0] d, input logic [3:0] e,
                      input logic b, input logic f);
    cmp({nm, "_dado"}, 0, {12'h0, dado4}, {12'h0, d});
    cmp({nm, "_en"}, 0, {12'h0, en4}, {12'h0, e});
    cmp({nm, "_blank"}, 0, {15'h0, blank4}, {15'h0, b});
    cmp({nm, "_fd"}, 0, {15'h0, fd4}, {15'h0, f});
  endtask

  task automatic wait_cyc0(input int target);
    int guard = 0;
    while (cyc[0] < target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc[0] != target) begin
      miscompares++;
      $display("FAIL wait_cyc0 got %0d expected %0d", cyc[0], target);
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    valor = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  logic [3:0] beef_d[4] = '{4'hF, 4'hE, 4'hE, 4'hB};
  logic [3:0] beef_e[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    // Reset with a load that must be ignored.
    valor = 16'hFFFF;
    load = 1'b1;
    repeat (3) @(negedge clk);
    lit4("rst", 4'h0, 4'b1110, 1'b0, 1'b0);
    load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Idle scan of a zero display.
    wait_cyc0(4);  lit4("idle1", 4'h0, 4'b1111, 1'b1, 1'b0);
    wait_cyc0(16); lit4("idle_fd", 4'h0, 4'b1110, 1'b0, 1'b1);

    // Load in SCAN1, visible only from next frame.
    wait_cyc0(20); pulse_load(16'h1234);
    lit4("hold", 4'h0, 4'b1111, 1'b1, 1'b0);
    wait_cyc0(32); lit4("s0_1234", 4'h4, 4'b1110, 1'b0, 1'b1);
    wait_cyc0(33); pulse_load(16'h1111);
    wait_cyc0(36); lit4("s1_1234", 4'h3, 4'b1101, 1'b0, 1'b0);
    wait_cyc0(40); lit4("s2_1234", 4'h2, 4'b1011, 1'b0, 1'b0);
    pulse_load(16'h2222);
    wait_cyc0(44); lit4("s3_1234", 4'h1, 4'b0111, 1'b0, 1'b0);
    wait_cyc0(48); lit4("last_wins", 4'h2, 4'b1110, 1'b0, 1'b1);
    wait_cyc0(60); lit4("last_wins3", 4'h2, 4'b0111, 1'b0, 1'b0);

    // Load on the boundary edge itself.
    wait_cyc0(63); pulse_load(16'h00A0);
    lit4("bnd_s0", 4'h0, 4'b1110, 1'b0, 1'b1);
    wait_cyc0(68); lit4("bnd_s1", 4'hA, 4'b1101, 1'b0, 1'b0);
    wait_cyc0(72); lit4("bnd_s2", 4'h0, 4'b1111, 1'b1, 1'b0);
    wait_cyc0(76); lit4("bnd_s3", 4'h0, 4'b1111, 1'b1, 1'b0);

    // Random loads with nibble-zeroing to exercise blanking.
    for (int n = 0; n < 1500; n++) begin
      logic [15:0] v;
      v = 16'($urandom);
      for (int j = 0; j < 4; j++)
        if ($urandom_range(0, 1) == 0) v[4*j +: 4] = 4'h0;
      valor = v;
      load = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    load = 1'b0;

    // DIV=1 instance showing BEEF.
    pulse_load(16'hBEEF);
    repeat (8) @(negedge clk);
    for (int g = 0; g < 4 && (cyc[1] % 4) != 0; g++) @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      cmp("beef_dado", 1, {12'h0, dado1}, {12'h0, beef_d[j]});
      cmp("beef_en", 1, {12'h0, en1}, {12'h0, beef_e[j]});
      cmp("beef_fd", 1, {15'h0, fd1}, {15'h0, (j == 0)});
      @(negedge clk);
    end

    // Async reset mid-SCAN2 with a pending value that must be lost.
    for (int g = 0; g < 16 && (cyc[0] % 16) != 8; g++) @(negedge clk);
    pulse_load(16'h5555);
    #2 rst_n = 1'b0;
    #1;
    lit4("async_rst", 4'h0, 4'b1110, 1'b0, 1'b0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc0(16); lit4("pend_lost", 4'h0, 4'b1110, 1'b0, 1'b1);
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
